// File: rtl/maze_ctrl_v2.sv
// maze_ctrl_v2 -- single-player maze step controller.
// Each tick erases the player, looks up the target cell, resolves
// wall/lava/ice/free, moves, and redraws through a plot handshake.
// Optional feature: define MAZE_CTRL_LIVES_EN to make lava cost a life
// and end the game (OVER) when lives reach zero. Without it lava only
// respawns the player and lives stays at LIVES.
module maze_ctrl_v2 #(
   parameter int X_W          = 8,
   parameter int Y_W          = 7,
   parameter int X_MAX        = 159,
   parameter int Y_MAX        = 119,
   parameter int X_START      = 0,
   parameter int Y_START      = 0,
   parameter int X_GOAL       = 158,
   parameter int Y_GOAL       = 118,
   parameter int FREEZE_TICKS = 4,
   parameter int LIVES        = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           tick,
   input  logic [2:0]     move,
   output logic           obs_req,
   output logic [X_W-1:0] obs_x,
   output logic [Y_W-1:0] obs_y,
   input  logic           obs_ack,
   input  logic [1:0]     obs_type,
   output logic           plot,
   output logic [X_W-1:0] px,
   output logic [Y_W-1:0] py,
   output logic [1:0]     color,
   input  logic           plot_done,
   output logic [X_W-1:0] xpos,
   output logic [Y_W-1:0] ypos,
   output logic [3:0]     lives,
   output logic           win,
   output logic           game_over,
   output logic [3:0]     state
);

   typedef enum logic [3:0] {
      ST_INIT    = 4'd0,
      ST_IDLE    = 4'd1,
      ST_ERASE   = 4'd2,
      ST_LOOKUP  = 4'd3,
      ST_RESOLVE = 4'd4,
      ST_MOVE    = 4'd5,
      ST_DRAW    = 4'd6,
      ST_FROZEN  = 4'd7,
      ST_WIN     = 4'd8,
      ST_OVER    = 4'd9
   } state_t;

   localparam logic [X_W-1:0] XS   = X_W'(X_START);
   localparam logic [Y_W-1:0] YS   = Y_W'(Y_START);
   localparam logic [X_W-1:0] XG   = X_W'(X_GOAL);
   localparam logic [Y_W-1:0] YG   = Y_W'(Y_GOAL);
   localparam logic [X_W-1:0] XMAX = X_W'(X_MAX);
   localparam logic [Y_W-1:0] YMAX = Y_W'(Y_MAX);
   localparam logic [7:0]     FT   = 8'(FREEZE_TICKS);
   localparam logic [3:0]     LV   = 4'(LIVES);

   state_t         st;
   logic [2:0]     mv;
   logic [1:0]     otype;
   logic [7:0]     frz_cnt;
   logic           frz_drawn;
   logic [X_W-1:0] tgt_x;
   logic [Y_W-1:0] tgt_y;
   logic           mv_valid;
   logic           at_edge;

   // Moore strobes; FROZEN only requests a plot until its freeze sprite is drawn
   assign plot    = (st == ST_ERASE) || (st == ST_DRAW) ||
                    ((st == ST_FROZEN) && !frz_drawn);
   assign obs_req = (st == ST_LOOKUP);
   assign state   = st;

   // Target cell of the latched move and whether it would leave the board
   always_comb begin
      tgt_x    = xpos;
      tgt_y    = ypos;
      mv_valid = 1'b1;
      at_edge  = 1'b0;
      case (mv)
         3'd1: begin at_edge = (xpos == '0);   tgt_x = xpos - 1'b1; end
         3'd2: begin at_edge = (xpos == XMAX); tgt_x = xpos + 1'b1; end
         3'd3: begin at_edge = (ypos == '0);   tgt_y = ypos - 1'b1; end
         3'd4: begin at_edge = (ypos == YMAX); tgt_y = ypos + 1'b1; end
         default: mv_valid = 1'b0;
      endcase
   end

   // Game FSM with all non-strobe outputs registered on the transitions
   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= ST_INIT;
         mv        <= '0;
         otype     <= '0;
         frz_cnt   <= '0;
         frz_drawn <= 1'b0;
         color     <= '0;
         px        <= '0;
         py        <= '0;
         obs_x     <= '0;
         obs_y     <= '0;
         xpos      <= XS;
         ypos      <= YS;
         lives     <= LV;
         win       <= 1'b0;
         game_over <= 1'b0;
      end else begin
         case (st)
            ST_INIT: begin
               xpos      <= XS;
               ypos      <= YS;
               lives     <= LV;
               frz_cnt   <= '0;
               win       <= 1'b0;
               game_over <= 1'b0;
               st        <= ST_IDLE;
            end
            ST_IDLE: begin
               if (tick) begin
                  mv    <= move;
                  px    <= xpos;
                  py    <= ypos;
                  color <= 2'd0;
                  st    <= ST_ERASE;
               end
            end
            ST_ERASE: begin
               if (plot_done) begin
                  if (!mv_valid || at_edge) begin
                     color <= 2'd1;
                     st    <= ST_DRAW;
                  end else begin
                     obs_x <= tgt_x;
                     obs_y <= tgt_y;
                     st    <= ST_LOOKUP;
                  end
               end
            end
            ST_LOOKUP: begin
               if (obs_ack) begin
                  otype <= obs_type;
                  st    <= ST_RESOLVE;
               end
            end
            ST_RESOLVE: begin
               case (otype)
                  2'd1: begin
                     px    <= xpos;
                     py    <= ypos;
                     color <= 2'd1;
                     st    <= ST_DRAW;
                  end
                  2'd2: begin
                     xpos  <= XS;
                     ypos  <= YS;
                     px    <= XS;
                     py    <= YS;
                     color <= 2'd1;
`ifdef MAZE_CTRL_LIVES_EN
                     lives <= lives - 4'd1;
                     if (lives == 4'd1) begin
                        game_over <= 1'b1;
                        st        <= ST_OVER;
                     end else begin
                        st <= ST_DRAW;
                     end
`else
                     st <= ST_DRAW;
`endif
                  end
                  2'd3: begin
                     px        <= xpos;
                     py        <= ypos;
                     color     <= 2'd2;
                     frz_cnt   <= FT;
                     frz_drawn <= 1'b0;
                     st        <= ST_FROZEN;
                  end
                  default: st <= ST_MOVE;
               endcase
            end
            ST_MOVE: begin
               xpos <= obs_x;
               ypos <= obs_y;
               if (obs_x == XG && obs_y == YG) begin
                  win <= 1'b1;
                  st  <= ST_WIN;
               end else begin
                  px    <= obs_x;
                  py    <= obs_y;
                  color <= 2'd1;
                  st    <= ST_DRAW;
               end
            end
            ST_DRAW: begin
               if (plot_done) st <= ST_IDLE;
            end
            ST_FROZEN: begin
               // plot_done wins over a coincident tick: ticks only count once drawn
               if (!frz_drawn) begin
                  if (plot_done) frz_drawn <= 1'b1;
               end else if (tick) begin
                  frz_cnt <= frz_cnt - 8'd1;
                  if (frz_cnt == 8'd1) st <= ST_IDLE;
               end
            end
            ST_WIN:  st <= ST_WIN;
            ST_OVER: st <= ST_OVER;
            default: st <= ST_INIT;
         endcase
      end
   end

endmodule

// File: doc/maze_ctrl_v2.md
MAZE_CTRL_V2 -- requirements
Module: maze_ctrl_v2

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  X_W, 8, x coordinate width
  Y_W, 7, y coordinate width
  X_MAX, 159, largest legal x
  Y_MAX, 119, largest legal y
  X_START/Y_START, 0/0, spawn position
  X_GOAL/Y_GOAL, 158/118, goal cell
  FREEZE_TICKS, 4, ticks lost on ice (1..255)
  LIVES, 3, lives at start (1..15).
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  in  1  clock
  reset  in  1  sync reset, active-high
  tick  in  1  one-cycle game step pulse
  move  in  3  0 none, 1 left, 2 right, 3 up, 4 down; 5-7 treated as none
  obs_req  out  1  lookup request
  obs_x/obs_y  out  X_W/Y_W  target cell of lookup
  obs_ack  in  1  lookup result valid
  obs_type  in  2  0 free, 1 wall, 2 lava, 3 ice
  plot  out  1  draw request
  px/py  out  X_W/Y_W  draw cell
  color  out  2  0 background, 1 player, 2 frozen
  plot_done  in  1  draw accepted
  xpos/ypos  out  X_W/Y_W  player position
  lives  out  4  remaining lives
  win  out  1  goal reached (sticky)
  game_over  out  1  lives exhausted (sticky)
  state  out  4  current FSM state.
REQ-003 Reset: reset, synchronous, active-high; clock clk.

Function
REQ-004 States SHALL be INIT=0, IDLE=1, ERASE=2, LOOKUP=3, RESOLVE=4, MOVE=5, DRAW=6, FROZEN=7, WIN=8, OVER=9.
REQ-005 INIT SHALL load xpos/ypos=START, lives=LIVES, freeze counter=0, clear win/game_over, then go to IDLE.
REQ-006 IDLE SHALL wait for tick; ticks arriving in any other state SHALL be dropped, not queued.
REQ-007 On tick, IDLE SHALL latch move and go to ERASE.
REQ-008 ERASE SHALL hold plot=1, color=0, px/py=current position until plot_done; if the latched move is none/invalid, go to DRAW, else go to LOOKUP.
REQ-009 Target cell SHALL be position ±1 on the move axis.
REQ-010 Left at x=0, right at x=X_MAX, up at y=0 or down at y=Y_MAX SHALL be treated as wall, with no obs_req issued.
REQ-011 LOOKUP SHALL hold obs_req=1 and obs_x/obs_y=target until obs_ack, capture obs_type in the ack cycle, then go to RESOLVE; obs_ack while obs_req=0 SHALL be ignored.
REQ-012 RESOLVE SHALL branch:
  wall -> DRAW, no move
  lava -> respawn at START, decrement lives, -> DRAW
  ice -> load freeze counter=FREEZE_TICKS, -> FROZEN
  free -> MOVE.
REQ-013 MOVE SHALL update xpos/ypos to target in one cycle; if the new position equals GOAL, set win and go to WIN, else go to DRAW.
REQ-014 DRAW SHALL hold plot=1, color=1 at current position until plot_done, then go to IDLE.
REQ-015 FROZEN SHALL hold plot=1, color=2 until plot_done, then keep plot=0 and decrement the counter on each tick; when the counter reaches 0, go to IDLE without moving.
REQ-016 WIN and OVER SHALL be absorbing until reset, ignoring tick and move.
REQ-017 Outputs plot and obs_req SHALL be Moore (decoded from state only); all other outputs SHALL be registered.
REQ-018 Simultaneous tick and plot_done SHALL be processed as plot_done only.

Reset
REQ-019 Reset SHALL override all inputs in any state, including mid-handshake, with next state INIT.
REQ-020 Reset values SHALL be: plot=0, obs_req=0, color=0, px/py=0, obs_x/obs_y=0, xpos/ypos=START, lives=LIVES, win=0, game_over=0, state=INIT.

Configuration
REQ-021 With MAZE_CTRL_LIVES_EN defined, lava SHALL decrement lives; reaching 0 SHALL set game_over and go to OVER instead of DRAW.
REQ-022 Without MAZE_CTRL_LIVES_EN, lava SHALL only respawn, lives SHALL stay constant at LIVES, game_over SHALL stay 0, and OVER SHALL be unreachable.

Verification
REQ-023 Bench SHALL cover: reset, tick, move=2, obs_type=0, immediate acks -> plot color0 at (0,0), obs_req target (1,0), xpos=1, plot color1 at (1,0), state back to 1.
REQ-024 Bench SHALL cover: position (0,5), move=1 -> no obs_req pulse, xpos stays 0, ERASE then DRAW plots.
REQ-025 Bench SHALL cover: position (3,3), obs_type=3, FREEZE_TICKS=4 -> one color2 plot, next 3 ticks ignored, 4th returns to IDLE, position (3,3).
REQ-026 Bench SHALL cover: MAZE_CTRL_LIVES_EN defined, LIVES=1, lava -> game_over=1, state=9, lives=0; without the macro -> respawn at START, lives=1.
REQ-027 Bench SHALL cover: position (157,118), move=2, free -> xpos=158, win=1, state=8, further ticks ignored.
REQ-028 Bench SHALL cover: reset asserted in LOOKUP with obs_req=1 -> next cycle obs_req=0, state=0, position=START.
